rom_fetch_streamer: RTL

Sequential address generator and read-response buffer that drives the address port of the SimROM model and consumes its data (1-cycle synchronous read latency). On a start command it fetches a block of consecutive words, buffers them in a small FIFO and presents them as a valid/ready stream to a downstream consumer, such as a loader or a CPU fetch stage in simulation benches. Credit-based issue guarantees no response is ever dropped under backpressure.

---
 rtl/rom_fetch_streamer_pkg.sv | 21 ++
 rtl/rom_fetch_streamer_if.sv | 44 ++++
 rtl/rom_fetch_streamer_fifo.sv | 71 +++++++
 rtl/rom_fetch_streamer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_streamer_pkg.sv
// -----------------------------------------------------------------------------
// rom_fetch_pkg
// Shared types for the ROM fetch streamer: the controller state encoding and a
// saturating increment used by the optional statistics counters.
// The FIFO entry struct depends on the streamer's width parameters, so it is
// declared inside rom_fetch_streamer using that module's localparams.
// No ports (package).
// -----------------------------------------------------------------------------
package rom_fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/rom_fetch_streamer_if.sv
// -----------------------------------------------------------------------------
// rom_fetch_streamer_if
// Bundles the command, ROM and stream signals of the ROM fetch streamer.
//   command : start, start_addr, length, abort
//   ROM     : rom_addr (to ROM), rom_data (from ROM, 1-cycle read latency)
//   stream  : out_valid, out_data, out_addr, out_ready
//   status  : busy, done
// Modports:
//   master - the streamer itself
//   slave  - the environment (command source, ROM model, stream consumer)
// -----------------------------------------------------------------------------
interface rom_fetch_streamer_if #(
    parameter int DATA_SIZE  = 1,
    parameter int ADDR_WIDTH = 8
);
    localparam int DATA_WIDTH = 8 * DATA_SIZE;

    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH:0]   length;
    logic                  abort;

    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_ready;

    logic                  busy;
    logic                  done;

    modport master (
        input  start, start_addr, length, abort, rom_data, out_ready,
        output rom_addr, out_valid, out_data, out_addr, busy, done
    );

    modport slave (
        output start, start_addr, length, abort, rom_data, out_ready,
        input  rom_addr, out_valid, out_data, out_addr, busy, done
    );

endinterface

// File: rtl/rom_fetch_streamer_fifo.sv
// -----------------------------------------------------------------------------
// rom_fetch_fifo
// Small synchronous FIFO holding ROM responses until the consumer takes them.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write one entry (ignored when full and not popping)
//   pop             remove the head entry (ignored when empty)
//   flush           discard all entries; dominates push and pop
//   count           number of stored entries (0..DEPTH)
//   head_valid      FIFO not empty
//   head_data       oldest entry, read from registered storage and pointer
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module rom_fetch_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data
);
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign do_pop     = pop && (count != '0);
    assign do_push    = push && ((count != CNT_WIDTH'(DEPTH)) || do_pop);
    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_WIDTH'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/rom_fetch_streamer.sv
// -----------------------------------------------------------------------------
// rom_fetch_streamer
// Walks a block of consecutive ROM addresses, captures the 1-cycle-latency
// read data into a small FIFO and presents it as a valid/ready stream tagged
// with the address each word came from. Reads are only issued when the FIFO
// plus the outstanding read still has room, so backpressure never drops data.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus (master)   start/start_addr/length/abort command, rom_addr/rom_data,
//                  out_valid/out_data/out_addr/out_ready stream, busy, done
//   stat_words     accepted-word count (only with ROM_FETCH_STATS_EN)
//   stat_stall     cycles with out_valid && !out_ready (only with
//                  ROM_FETCH_STATS_EN)
// Optional feature macro: ROM_FETCH_STATS_EN
// -----------------------------------------------------------------------------
module rom_fetch_streamer
    import rom_fetch_pkg::*;
#(
    parameter int DATA_SIZE  = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rom_fetch_streamer_if.master bus
`ifdef ROM_FETCH_STATS_EN
    ,
    output logic [31:0]          stat_words,
    output logic [31:0]          stat_stall
`endif
);
    localparam int DATA_WIDTH = 8 * DATA_SIZE;
    localparam int LEN_WIDTH  = ADDR_WIDTH + 1;
    localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] addr;
    } fifo_entry_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] tag;
    logic [LEN_WIDTH-1:0]  issue_left;
    logic [LEN_WIDTH-1:0]  deliver_left;
    logic                  inflight;
    logic                  done_q;
    logic [CNT_WIDTH-1:0]  fifo_count;
    logic                  head_valid;
    fifo_entry_t           push_entry;
    fifo_entry_t           head_entry;

    logic load;
    logic flush;
    logic issue;
    logic push;
    logic pop;
    logic last_pop;
    logic done_next;

    // A start always cancels whatever is running (even alongside abort);
    // a zero-length start never enters RUN and only produces a done pulse.
    assign load      = bus.start && (bus.length != '0);
    assign flush     = bus.start || (bus.abort && state == RUN);
    assign pop       = head_valid && bus.out_ready;
    assign last_pop  = (state == RUN) && pop && (deliver_left == LEN_WIDTH'(1));
    assign done_next = (bus.start && bus.length == '0) || (last_pop && !flush);

    // Credit check: stored words plus the read still in the ROM pipeline must
    // leave a free slot. A pop in this cycle is deliberately not counted.
    assign issue = (state == RUN) && !flush && (issue_left != '0) &&
                   ((32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH));

    // The response of a squashed read is dropped rather than buffered.
    assign push = inflight && !flush;

    assign push_entry.data = bus.rom_data;
    assign push_entry.addr = tag;

    rom_fetch_fifo #(
        .WIDTH (DATA_WIDTH + ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .flush      (flush),
        .count      (fifo_count),
        .head_valid (head_valid),
        .head_data  (head_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (load) begin
                    state_next = RUN;
                end else if (flush || last_pop) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address counter, remaining-word counters and the one-deep read pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= '0;
            tag          <= '0;
            issue_left   <= '0;
            deliver_left <= '0;
            inflight     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q   <= done_next;
            inflight <= issue;
            if (issue) begin
                tag        <= pc;
                pc         <= pc + ADDR_WIDTH'(1);
                issue_left <= issue_left - LEN_WIDTH'(1);
            end
            if (load) begin
                pc           <= bus.start_addr;
                issue_left   <= bus.length;
                deliver_left <= bus.length;
            end else if (pop) begin
                deliver_left <= deliver_left - LEN_WIDTH'(1);
            end
        end
    end

    assign bus.rom_addr  = pc;
    assign bus.out_valid = head_valid;
    assign bus.out_data  = head_entry.data;
    assign bus.out_addr  = head_entry.addr;
    assign bus.busy      = (state == RUN);
    assign bus.done      = done_q;

`ifdef ROM_FETCH_STATS_EN
    // Statistics survive aborts and restarts; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words <= '0;
            stat_stall <= '0;
        end else begin
            if (pop) begin
                stat_words <= sat_inc(stat_words);
            end
            if (head_valid && !bus.out_ready) begin
                stat_stall <= sat_inc(stat_stall);
            end
        end
    end
`endif

endmodule
